// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and Out_ready; slave is the adder.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             In_valid;
  logic             In_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             Out_valid;
  logic             Out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Overflow;

  modport master (
    output In_valid, A, B, Cin, Sub, Out_ready,
    input  In_ready, Out_valid, S, Cout, Overflow
  );

  modport slave (
    input  In_valid, A, B, Cin, Sub, Out_ready,
    output In_ready, Out_valid, S, Cout, Overflow
  );

endinterface

// File: rtl/pipelined_adder.sv
// Pipelined segmented adder/subtractor: one SEG-bit segment per stage, carry registered between stages.
// Optional signed saturation of S on overflow when PIPE_ADDER_SAT_EN is defined.
module pipelined_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input logic              Clk,
  input logic              Reset,
  pipelined_adder_if.slave bus
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned SEGW   = SEG + 1;

  logic             adv;
  logic             xfer;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Global stall: every stage moves only when the output slot is free or being taken.
  assign adv          = !bus.Out_valid || bus.Out_ready;
  assign bus.In_ready = adv && !Reset;
  assign xfer         = bus.In_valid && bus.In_ready;
  assign b_eff        = bus.Sub ? ~bus.B : bus.B;
  assign c0           = bus.Sub | bus.Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LOW = k * SEG;
    localparam int unsigned REM = WIDTH - LOW;

    logic             vld_in;
    logic             cy_in;
    logic [REM-1:0]   a_in;
    logic [REM-1:0]   b_in;
    logic [SEG:0]     seg;
    logic [LOW+SEG-1:0] sum_d;

    if (k == 0) begin : g_head
      assign vld_in = xfer;
      assign cy_in  = c0;
      assign a_in   = bus.A;
      assign b_in   = b_eff;
      assign sum_d  = seg[SEG-1:0];
    end else begin : g_link
      assign vld_in = g_stg[k-1].g_reg.vld_q;
      assign cy_in  = g_stg[k-1].g_reg.cy_q;
      assign a_in   = g_stg[k-1].g_reg.a_q;
      assign b_in   = g_stg[k-1].g_reg.b_q;
      assign sum_d  = {seg[SEG-1:0], g_stg[k-1].g_reg.sum_q};
    end

    assign seg = SEGW'(a_in[SEG-1:0]) + SEGW'(b_in[SEG-1:0]) + SEGW'(cy_in);

    if (k < STAGES - 1) begin : g_reg
      logic                 vld_q;
      logic                 cy_q;
      logic [REM-SEG-1:0]   a_q;
      logic [REM-SEG-1:0]   b_q;
      logic [LOW+SEG-1:0]   sum_q;

      // Intermediate stage: keep low sum bits, carry and the not-yet-added operand bits.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          vld_q <= 1'b0;
          cy_q  <= 1'b0;
          a_q   <= '0;
          b_q   <= '0;
          sum_q <= '0;
        end else if (adv) begin
          vld_q <= vld_in;
          cy_q  <= seg[SEG];
          a_q   <= a_in[REM-1:SEG];
          b_q   <= b_in[REM-1:SEG];
          sum_q <= sum_d;
        end
      end
    end else begin : g_out
      logic             vld_q;
      logic             cout_q;
      logic             ovf_q;
      logic [WIDTH-1:0] s_q;
      logic             ovf_c;
      logic [WIDTH-1:0] s_c;

      // The top segment still carries the sign bits of A and Beff.
      always_comb begin
        ovf_c = (a_in[SEG-1] == b_in[SEG-1]) && (sum_d[WIDTH-1] != a_in[SEG-1]);
        s_c   = sum_d;
`ifdef PIPE_ADDER_SAT_EN
        if (ovf_c) begin
          s_c = a_in[SEG-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          vld_q  <= 1'b0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          s_q    <= '0;
        end else if (adv) begin
          vld_q  <= vld_in;
          cout_q <= seg[SEG];
          ovf_q  <= ovf_c;
          s_q    <= s_c;
        end
      end

      assign bus.Out_valid = vld_q;
      assign bus.S         = s_q;
      assign bus.Cout      = cout_q;
      assign bus.Overflow  = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (SEG=8 main instance, SEG=WIDTH single-stage instance).
module tb_pipelined_adder;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned SEG    = 8;
  localparam int unsigned STAGES = WIDTH / SEG;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;
    int               cyc;
    bit               lat;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;

  pipelined_adder_if #(.WIDTH(WIDTH)) bus ();
  pipelined_adder_if #(.WIDTH(WIDTH)) bus1 ();

  pipelined_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  pipelined_adder #(.WIDTH(WIDTH), .SEG(WIDTH)) dut1 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus1.slave)
  );

  always #5 Clk = ~Clk;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  exp_t             sb[$];
  bit               rand_ready = 1'b0;
  bit               prev_stall = 1'b0;
  logic [WIDTH+2:0] prev_out   = '0;
  logic [WIDTH-1:0] ovf_s;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    exp_t             r;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   full;
    be     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + (WIDTH+1)'(sub | cin);
    r.s    = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ov   = (a[WIDTH-1] == be[WIDTH-1]) && (r.s[WIDTH-1] != a[WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
    if (r.ov) r.s = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    r.cyc = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic cout, input logic ov);
    exp_t r;
    r.s = s; r.cout = cout; r.ov = ov; r.cyc = 0; r.lat = 1'b1;
    return r;
  endfunction

  always @(posedge Clk) cyc <= cyc + 1;

  // Random backpressure on the main output.
  always @(posedge Clk) begin
    if (rand_ready) begin
      #1 bus.Out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: handshake rule, stall stability, in-order result check.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      sb.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", 64'({bus.Out_valid, bus.Cout, bus.Overflow, bus.S}), 64'(prev_out));
      check("in_ready_rule", 64'(bus.In_ready), 64'(!(bus.Out_valid && !bus.Out_ready)));
      if (bus.Out_valid && bus.Out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("s", 64'(bus.S), 64'(e.s));
          check("cout", 64'(bus.Cout), 64'(e.cout));
          check("overflow", 64'(bus.Overflow), 64'(e.ov));
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(STAGES));
        end
      end
      prev_stall = bus.Out_valid && !bus.Out_ready;
      prev_out   = {bus.Out_valid, bus.Cout, bus.Overflow, bus.S};
    end
  end

  task automatic drive_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input exp_t e_in);
    exp_t e;
    bus.A = a; bus.B = b; bus.Cin = cin; bus.Sub = sub;
    bus.In_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge Clk);
      if (bus.In_ready) begin
        e = e_in;
        e.cyc = cyc;
        sb.push_back(e);
        @(posedge Clk); #1;
        bus.In_valid = 1'b0;
        return;
      end
      @(posedge Clk); #1;
    end
    check("accept_timeout", 64'(0), 64'(1));
    bus.In_valid = 1'b0;
  endtask

  task automatic directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic sub, input exp_t e);
    drive_one(a, b, cin, sub, e);
    repeat (STAGES + 2) @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;

`ifdef PIPE_ADDER_SAT_EN
    ovf_s = 32'h7FFF_FFFF;
`else
    ovf_s = 32'h8000_0000;
`endif
    Reset = 1'b1;
    bus.In_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Cin = 1'b0; bus.Sub = 1'b0; bus.Out_ready = 1'b1;
    bus1.In_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.Cin = 1'b0; bus1.Sub = 1'b0; bus1.Out_ready = 1'b1;

    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_out_valid", 64'(bus.Out_valid), 64'(0));
    check("rst_s", 64'(bus.S), 64'(0));
    check("rst_cout", 64'(bus.Cout), 64'(0));
    check("rst_overflow", 64'(bus.Overflow), 64'(0));
    check("rst_in_ready", 64'(bus.In_ready), 64'(0));
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("in_ready_after_rst", 64'(bus.In_ready), 64'(1));
    @(posedge Clk); #1;

    // Directed corner cases with exact latency.
    directed(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0));
    directed(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(ovf_s, 1'b0, 1'b1));
    directed(32'h5, 32'h7, 1'b1, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
    directed(32'h7, 32'h5, 1'b0, 1'b1, mk(32'h0000_0002, 1'b1, 1'b0));
    directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, mk(32'h7FFF_FFFF ^ ((ovf_s == 32'h7FFF_FFFF) ? 32'hFFFF_FFFF : 32'h0), 1'b1, 1'b1));

    // Back-to-back random traffic under random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a   = (i % 9 == 0) ? 32'h7FFF_FFFF : 32'($urandom());
      b   = (i % 11 == 0) ? 32'h8000_0000 : 32'($urandom());
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      drive_one(a, b, cin, sub, model(a, b, cin, sub));
    end
    rand_ready = 1'b0;
    @(posedge Clk); #2;
    bus.Out_ready = 1'b1;
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge Clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'(0));

    // Reset with three pairs in flight.
    for (int i = 0; i < 3; i++) begin
      a = 32'($urandom()); b = 32'($urandom());
      drive_one(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
    end
    Reset = 1'b1;
    @(negedge Clk);
    check("in_ready_in_rst", 64'(bus.In_ready), 64'(0));
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("flush_out_valid", 64'(bus.Out_valid), 64'(0));
    check("flush_s", 64'(bus.S), 64'(0));
    check("flush_in_ready", 64'(bus.In_ready), 64'(1));
    @(posedge Clk); #1;
    directed(32'h1234_5678, 32'h0101_0101, 1'b0, 1'b0, mk(32'h1335_5779, 1'b0, 1'b0));
    check("no_stale", 64'(sb.size()), 64'(0));

    // Single-stage build: result one cycle after acceptance.
    bus1.A = 32'h1234_5678; bus1.B = 32'h1111_1111; bus1.Cin = 1'b0; bus1.Sub = 1'b0;
    bus1.In_valid = 1'b1;
    @(negedge Clk);
    check("w_in_ready", 64'(bus1.In_ready), 64'(1));
    check("w_idle", 64'(bus1.Out_valid), 64'(0));
    @(posedge Clk); #1;
    bus1.In_valid = 1'b0;
    @(negedge Clk);
    check("w_out_valid", 64'(bus1.Out_valid), 64'(1));
    check("w_s", 64'(bus1.S), 64'(32'h2345_6789));
    check("w_cout", 64'(bus1.Cout), 64'(0));
    @(posedge Clk); #1;
    @(negedge Clk);
    check("w_bubble", 64'(bus1.Out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
